depth_fb_writer: RTL

// Final stage after the shader. Holds the rasterizer's pixel (hcount, vcount, depth) while the shader

---
 rtl/graphics_pkg.sv | 28 ++
 rtl/fb_clear_sweep.sv | 50 +++++
 rtl/depth_fb_writer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/graphics_pkg.sv
// Shared graphics definitions: depth limit, RGB565 pixel, writer FSM states,
// and the framebuffer address-width helper.
package graphics_pkg;

  // Wide enough to be cast down to any supported depth width.
  localparam logic [63:0] Z_MAX = '1;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PENDING,
    ST_ZREAD,
    ST_ZWAIT,
    ST_TEST,
    ST_WRITE,
    ST_CLEAR
  } fb_state_e;

  function automatic int fb_addr_width(input int h_res, input int v_res);
    return (h_res * v_res > 1) ? $clog2(h_res * v_res) : 1;
  endfunction

endpackage

// File: rtl/fb_clear_sweep.sv
// Clear sweep: walks every framebuffer address once, one per cycle, and
// pulses done in the cycle after the last address. Reset aborts a sweep.
module fb_clear_sweep #(
  parameter int NUM_PIXELS = 57600,
  parameter int ADDR_W     = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  output logic              busy_out,
  output logic              last_out,
  output logic              done_out,
  output logic [ADDR_W-1:0] addr_out
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  logic              active_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;

  assign last_out = active_q && (addr_q == LAST_ADDR);
  assign busy_out = active_q;
  assign done_out = done_q;
  assign addr_out = addr_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      active_q <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
    end else begin
      done_q <= last_out;
      if (active_q) begin
        if (last_out) begin
          active_q <= 1'b0;
          addr_q   <= '0;
        end else begin
          addr_q <= addr_q + ADDR_W'(1);
        end
      end else if (start_in) begin
        active_q <= 1'b1;
        addr_q   <= '0;
      end
    end
  end

endmodule

// File: rtl/depth_fb_writer.sv
// Post-shader pixel stage: holds the rasterized pixel while the shader runs,
// z-tests it against the z-buffer, writes colour and depth, and runs the clear sweep.
module depth_fb_writer
  import graphics_pkg::*;
#(
  parameter int                     H_RES       = 320,
  parameter int                     V_RES       = 180,
  parameter int                     Z_WIDTH     = 16,
  parameter int                     COLOR_WIDTH = 16,
  parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0,
  localparam int                    HW          = $clog2(H_RES),
  localparam int                    VW          = $clog2(V_RES),
  localparam int                    ADDR_W      = fb_addr_width(H_RES, V_RES)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   pix_valid_in,
  output logic                   pix_ready_out,
  input  logic [HW-1:0]          hcount_in,
  input  logic [VW-1:0]          vcount_in,
  input  logic [Z_WIDTH-1:0]     depth_in,
  input  logic [COLOR_WIDTH-1:0] color_in,
  input  logic                   color_valid_in,
  input  logic                   short_circuit_in,
  output logic                   shader_ready_out,
  input  logic                   clear_start_in,
  output logic                   clear_busy_out,
  output logic                   clear_done_out,
  output logic [ADDR_W-1:0]      z_raddr_out,
  input  logic [Z_WIDTH-1:0]     z_rdata_in,
  output logic                   z_we_out,
  output logic [ADDR_W-1:0]      z_waddr_out,
  output logic [Z_WIDTH-1:0]     z_wdata_out,
  output logic                   fb_we_out,
  output logic [ADDR_W-1:0]      fb_addr_out,
  output logic [COLOR_WIDTH-1:0] fb_wdata_out
);

  fb_state_e              state_q, state_d;
  logic [ADDR_W-1:0]      addr_q;
  logic [Z_WIDTH-1:0]     depth_q;
  logic [COLOR_WIDTH-1:0] color_q;
  logic                   in_range_q;
  logic                   we_q;

  logic                   sweep_busy, sweep_last, sweep_done;
  logic [ADDR_W-1:0]      sweep_addr;

  logic                   clear_go, accept, color_take;
  logic [ADDR_W-1:0]      pix_addr;
  logic                   pix_in_range;

  assign clear_go   = (state_q == ST_IDLE) && clear_start_in;
  assign accept     = (state_q == ST_IDLE) && !clear_start_in && pix_valid_in;
  assign color_take = (state_q == ST_PENDING) && color_valid_in && !short_circuit_in;

  assign pix_addr     = ADDR_W'(vcount_in) * ADDR_W'(H_RES) + ADDR_W'(hcount_in);
  assign pix_in_range = (int'(hcount_in) < H_RES) && (int'(vcount_in) < V_RES);

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start_in)    state_d = ST_CLEAR;
        else if (pix_valid_in) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (short_circuit_in)    state_d = ST_IDLE;
        else if (color_valid_in) state_d = ST_ZREAD;
      end
      ST_ZREAD: state_d = ST_ZWAIT;
      ST_ZWAIT: state_d = ST_TEST;
      ST_TEST:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      ST_CLEAR: if (sweep_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      depth_q    <= '0;
      color_q    <= '0;
      in_range_q <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= pix_addr;
        depth_q    <= depth_in;
        in_range_q <= pix_in_range;
      end
      if (color_take) color_q <= color_in;
      // z_rdata_in is valid in TEST; ties fail so the first-drawn pixel keeps the spot.
      we_q <= (state_q == ST_TEST) && in_range_q && (depth_q < z_rdata_in);
    end
  end

  fb_clear_sweep #(
    .NUM_PIXELS (H_RES * V_RES),
    .ADDR_W     (ADDR_W)
  ) u_sweep (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start_in (clear_go),
    .busy_out (sweep_busy),
    .last_out (sweep_last),
    .done_out (sweep_done),
    .addr_out (sweep_addr)
  );

  assign pix_ready_out    = (state_q == ST_IDLE);
  assign shader_ready_out = (state_q == ST_PENDING);
  assign clear_busy_out   = sweep_busy;
  assign clear_done_out   = sweep_done;

  assign z_raddr_out  = addr_q;
  assign z_we_out     = we_q | sweep_busy;
  assign fb_we_out    = we_q | sweep_busy;
  assign z_waddr_out  = sweep_busy ? sweep_addr : addr_q;
  assign fb_addr_out  = sweep_busy ? sweep_addr : addr_q;
  assign z_wdata_out  = sweep_busy ? Z_WIDTH'(Z_MAX) : depth_q;
  assign fb_wdata_out = sweep_busy ? CLEAR_COLOR : color_q;

endmodule
